mux_stream_n: RTL and testbench

- Parametrised registered N-channel, W-bit stream multiplexer; successor to the 1-bit 2:1 combinational mux.
- Each input channel has a valid/ready handshake; one channel's word is forwarded per transfer into a single output register.
- Two modes, set per cycle by an input pin: fixed select and round-robin arbitration.
- Sits between operand sources and the sign-magnitude adder datapath so that several producers can share one adder.

---
 rtl/mux_stream_n.sv | 116 +++++++++++
 tb/tb_mux_stream_n.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_stream_n.sv
`default_nettype none
// ============================================================================
// Module   : mux_stream_n
// Brief    : Registered N-channel valid/ready stream mux, fixed-select or
//            round-robin arbitration, single output register.
// Revision : 1.0  initial release
// ============================================================================
module mux_stream_n #(
    parameter int NCH = 4,
    parameter int W   = 8,
    parameter int SW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic [SW-1:0]    sel,
    input  logic [NCH-1:0]   in_valid,
    input  logic [NCH*W-1:0] in_data,
    output logic [NCH-1:0]   in_ready,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic [SW-1:0]    out_ch,
    input  logic             out_ready
);

    localparam logic [SW-1:0] C_PTR_RST = SW'(NCH - 1);

    logic             r_valid;
    logic [W-1:0]     r_data;
    logic [SW-1:0]    r_ch;
    logic [SW-1:0]    r_rr_ptr;

    logic             w_load;
    logic [NCH-1:0]   w_fix_mask;
    logic [NCH-1:0]   w_rr_gnt;
    logic [SW-1:0]    w_rr_idx;
    logic             w_rr_hit;
    logic [SW-1:0]    w_idx;
    logic             w_xfer;
    logic [W-1:0]     w_data;

    assign w_load = ~r_valid | out_ready;

    // Fixed-select mask is independent of in_valid; out-of-range sel gives an empty mask.
    always_comb begin
        w_fix_mask = '0;
        for (int i = 0; i < NCH; i++) begin
            w_fix_mask[i] = (int'(sel) == i);
        end
    end

    // Round-robin search starts one past the last granted channel.
    always_comb begin
        int w_pos;
        w_pos    = 0;
        w_rr_gnt = '0;
        w_rr_idx = '0;
        w_rr_hit = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            w_pos = int'(r_rr_ptr) + k;
            if (w_pos >= NCH) begin
                w_pos = w_pos - NCH;
            end
            if (!w_rr_hit && in_valid[w_pos]) begin
                w_rr_hit        = 1'b1;
                w_rr_idx        = SW'(w_pos);
                w_rr_gnt[w_pos] = 1'b1;
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_n) begin
            in_ready = (mode ? w_rr_gnt : w_fix_mask) & {NCH{w_load}};
        end
    end

    assign w_idx  = mode ? w_rr_idx : sel;
    assign w_xfer = |(in_valid & in_ready);

    always_comb begin
        w_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (int'(w_idx) == i) begin
                w_data = in_data[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_ch     <= '0;
            r_rr_ptr <= C_PTR_RST;
        end else begin
            if (w_xfer) begin
                r_valid <= 1'b1;
                r_data  <= w_data;
                r_ch    <= w_idx;
                if (mode) begin
                    r_rr_ptr <= w_idx;
                end
            end else if (out_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_stream_n
// Brief    : Directed self-checking bench for mux_stream_n (NCH=4 and NCH=3).
// Revision : 1.0  initial release
// ============================================================================
module tb_mux_stream_n;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        mode;
    logic [1:0]  sel;
    logic [3:0]  in_valid;
    logic [31:0] in_data;
    logic [3:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;
    logic        out_ready;

    logic        b_mode;
    logic [1:0]  b_sel;
    logic [2:0]  b_in_valid;
    logic [23:0] b_in_data;
    logic [2:0]  b_in_ready;
    logic        b_out_valid;
    logic [7:0]  b_out_data;
    logic [1:0]  b_out_ch;
    logic        b_out_ready;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mux_stream_n #(.NCH(4), .W(8), .SW(2)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
    );

    mux_stream_n #(.NCH(3), .W(8), .SW(2)) u_dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (b_mode),
        .sel       (b_sel),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_ch    (b_out_ch),
        .out_ready (b_out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic [1:0] c);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".ch"},    32'(out_ch),    32'(c));
    endtask

    initial begin
        logic [1:0] rr_exp [6];
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst_n     = 1'b0;
        mode      = 1'b0;
        sel       = 2'd0;
        in_valid  = 4'b1111;
        in_data   = 32'h0;
        out_ready = 1'b1;
        b_mode      = 1'b0;
        b_sel       = 2'd3;
        b_in_valid  = 3'b000;
        b_in_data   = 24'h332211;
        b_out_ready = 1'b1;

        // Reset state
        tick();
        tick();
        check_out("rst", 1'b0, 8'h00, 2'd0);
        check("rst.in_ready", 32'(in_ready), 32'h0);
        rst_n    = 1'b1;
        in_valid = 4'b0000;

        // Mode 0 forwarding, ch2 = A5
        mode     = 1'b0;
        sel      = 2'd2;
        in_data  = 32'h00A5_0000;
        in_valid = 4'b0100;
        #1;
        check("m0.in_ready", 32'(in_ready), 32'h4);
        tick();
        check_out("m0.fwd", 1'b1, 8'hA5, 2'd2);
        in_valid = 4'b0000;
        tick();
        check_out("m0.drain", 1'b0, 8'hA5, 2'd2);

        // Backpressure on ch1
        sel       = 2'd1;
        in_data   = 32'h0000_3C00;
        in_valid  = 4'b0010;
        out_ready = 1'b0;
        tick();
        check_out("bp.load", 1'b1, 8'h3C, 2'd1);
        in_data = 32'h0000_3D00;
        for (int i = 0; i < 3; i++) begin
            check("bp.in_ready", 32'(in_ready), 32'h0);
            tick();
            check_out("bp.hold", 1'b1, 8'h3C, 2'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp.release_ready", 32'(in_ready), 32'h2);
        tick();
        check_out("bp.refill", 1'b1, 8'h3D, 2'd1);
        in_valid = 4'b0000;
        tick();
        check("bp.empty", 32'(out_valid), 32'h0);

        // Round-robin fairness, pointer still at reset value
        mode     = 1'b1;
        in_data  = 32'h1312_1110;
        in_valid = 4'b1111;
        #1;
        check("rr.first_ready", 32'(in_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_out("rr.seq", 1'b1, 8'h10 + 8'(rr_exp[i]), rr_exp[i]);
        end
        in_valid = 4'b0000;
        #1;
        check("rr.idle_ready", 32'(in_ready), 32'h0);
        tick();
        check("rr.drain", 32'(out_valid), 32'h0);

        // Round-robin skip: pointer now 1, only ch3 and ch1 valid
        in_valid = 4'b1010;
        #1;
        check("skip.ready", 32'(in_ready), 32'h8);
        tick();
        check_out("skip.0", 1'b1, 8'h13, 2'd3);
        tick();
        check_out("skip.1", 1'b1, 8'h11, 2'd1);
        tick();
        check_out("skip.2", 1'b1, 8'h13, 2'd3);
        tick();
        check_out("skip.3", 1'b1, 8'h11, 2'd1);

        // Asynchronous reset mid-stream, then first RR grant must be ch0
        #2;
        rst_n = 1'b0;
        #1;
        check_out("arst", 1'b0, 8'h00, 2'd0);
        check("arst.in_ready", 32'(in_ready), 32'h0);
        tick();
        rst_n    = 1'b1;
        in_valid = 4'b1111;
        #1;
        check("arst.rr_ready", 32'(in_ready), 32'h1);
        tick();
        check_out("arst.rr0", 1'b1, 8'h10, 2'd0);

        // NCH=3 instance, invalid select
        b_in_valid = 3'b111;
        for (int i = 0; i < 5; i++) begin
            check("inv.in_ready", 32'(b_in_ready), 32'h0);
            tick();
            check("inv.out_valid", 32'(b_out_valid), 32'h0);
        end
        b_sel = 2'd2;
        #1;
        check("b.sel2_ready", 32'(b_in_ready), 32'h4);
        tick();
        check("b.sel2_data", 32'(b_out_data), 32'h33);
        check("b.sel2_ch", 32'(b_out_ch), 32'h2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
